ram8: RTL
=========

RAM8 -- requirements
Module: ram8

Interface
REQ-001 Parameter: WIDTH, default 16, data width of every register and port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 Port: inData  input  WIDTH  write data.
REQ-005 Port: load  input  1  write enable.
REQ-006 Port: address  input  3  write address; also port A read address.
REQ-007 Port: addressB  input  3  port B read address.
REQ-008 Port: out  output  WIDTH  port A read data.
REQ-009 Port: outB  output  WIDTH  port B read data.
REQ-010 Port: written  output  8  per-register flag, bit i = register i written since reset.

Function
REQ-011 Storage: eight WIDTH-bit registers, R0..R7, plus the 8-bit written flag vector.
REQ-012 Write: on rising edge with load=1 and reset=0, R[address] takes inData; other registers hold.
REQ-013 load=0: all registers hold regardless of inData/address.
REQ-014 Read port A: out = R[address], combinational, no added latency.
REQ-015 Read port B: outB = R[addressB], combinational, independent of port A.
REQ-016 Read-during-write: in the write cycle out/outB show the pre-edge value; new value visible immediately after the edge (Hack semantics, no bypass).
REQ-017 Same address on both ports: out and outB identical.
REQ-018 Read decode: 8-way selection tree of 2-way muxes; write decode: 8-way demux of load; no X on out for any known address.
REQ-019 written[address] set to 1 on every accepted write; bits never clear except by reset.
REQ-020 Data width rule: inData stored unmodified, no truncation or sign change; all WIDTH bits writable.
REQ-021 Address wrap: none; address 7 and 0 are independent registers.
REQ-022 Outputs driven X-free whenever address/addressB known after first reset.

Reset
REQ-023 reset=1 at rising edge: R0..R7 = 0, written = 8'h00, out = 0, outB = 0 after the edge.
REQ-024 reset dominates load: simultaneous reset=1 and load=1 writes nothing; register cleared, written bit stays 0.
REQ-025 Reset mid-operation: asserted between writes, all prior contents lost; first write after reset deasserts behaves as REQ-012.
REQ-026 Before first reset, contents undefined; the bench applies reset first.

Verification
REQ-027 Reset, then read all 8 addresses on both ports -> out=0, outB=0, written=8'h00.
REQ-028 Write 16'hA5A5 to address 3 (load=1), next cycle load=0, address=3, addressB=2 -> out=16'hA5A5, outB=0, written=8'h08.
REQ-029 Write 16'h1234 to address 5 with addressB=5 -> in write cycle outB=old value 0; after edge outB=16'h1234.
REQ-030 Write i*16'h1111 to each address i (0..7), then read all with port A and port B reversed (addressB=7-address) -> each value matches, written=8'hFF.
REQ-031 load=1, reset=1, address=6, inData=16'hFFFF -> R6=0, written[6]=0; then load=1, reset=0 -> R6=16'hFFFF.
REQ-032 load=0 with inData=16'hDEAD for all addresses -> contents and written unchanged; bench reports per-test PASSED/FAILED and overall result.

Source files
------------

// File: rtl/ram8_if.sv
// ram8_if -- bus bundle for the eight-register dual-read RAM.
//   inData   : write data (WIDTH bits)
//   load     : write enable
//   address  : write address, also the port A read address
//   addressB : port B read address
//   out      : port A read data
//   outB     : port B read data
//   written  : bit i set once register i has been written since reset
// The master modport belongs to whoever drives writes and read addresses;
// the slave modport is the RAM itself.
interface ram8_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inData;
    logic             load;
    logic [2:0]       address;
    logic [2:0]       addressB;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] outB;
    logic [7:0]       written;

    modport master (
        output inData, load, address, addressB,
        input  out, outB, written
    );

    modport slave (
        input  inData, load, address, addressB,
        output out, outB, written
    );
endinterface

// File: rtl/ram8.sv
// ram8 -- eight WIDTH-bit registers with one write port and two
// combinational read ports, plus a per-register "written since reset" flag.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous active-high clear of all registers and flags;
//           takes priority over a simultaneous write
//   bus   : ram8_if slave modport (write data/enable/address, two read
//           addresses, two read data outputs, written flag vector)
// Reads are not bypassed: during a write cycle both ports still show the
// old contents and the new value appears just after the clock edge.
module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   reset,
    ram8_if.slave  bus
);

    logic [WIDTH-1:0] r_reg [8];
    logic [7:0]       wr_sel;
    logic [7:0]       written_reg;

    // Write decode: one-hot demux of load across the eight registers.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr
            assign wr_sel[gi] = bus.load & (bus.address == 3'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_reg[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    r_reg[gi] <= bus.inData;
                end
            end
        end
    endgenerate

    // Flags only ever set between resets; wr_sel is already one-hot.
    always_ff @(posedge clk) begin
        if (reset) begin
            written_reg <= 8'h00;
        end else begin
            written_reg <= written_reg | wr_sel;
        end
    end

    // Read decode: a three-level tree of 2:1 muxes per read port.
    // Index 0 is port A (address), index 1 is port B (addressB).
    logic [2:0]       rd_addr [2];
    logic [WIDTH-1:0] lvl1    [2][4];
    logic [WIDTH-1:0] lvl2    [2][2];
    logic [WIDTH-1:0] rd_data [2];

    assign rd_addr[0] = bus.address;
    assign rd_addr[1] = bus.addressB;

    generate
        for (genvar pi = 0; pi < 2; pi++) begin : g_rd
            for (genvar gi = 0; gi < 4; gi++) begin : g_l1
                assign lvl1[pi][gi] = rd_addr[pi][0] ? r_reg[2*gi+1] : r_reg[2*gi];
            end
            for (genvar gi = 0; gi < 2; gi++) begin : g_l2
                assign lvl2[pi][gi] = rd_addr[pi][1] ? lvl1[pi][2*gi+1] : lvl1[pi][2*gi];
            end
            assign rd_data[pi] = rd_addr[pi][2] ? lvl2[pi][1] : lvl2[pi][0];
        end
    endgenerate

    assign bus.out     = rd_data[0];
    assign bus.outB    = rd_data[1];
    assign bus.written = written_reg;

endmodule
